// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the bit-serial magnitude comparator.
//  - state_t    : comparator FSM states.
//  - CMP_*      : one-hot result encodings, ordered {eq, ls, gt}.
//  - cnt_width(): bit-counter width for a given operand width (min 1 bit).
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  // A W=1 walk still needs a 1-bit counter, so clamp the width to 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// cmp_bit_slice: combinational 1-bit unsigned compare.
// Ports:
//  a_bit, b_bit : bits under comparison
//  eq, lt, gt   : one-hot result (a==b, a<b, a>b)
module cmp_bit_slice (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq,
  output logic lt,
  output logic gt
);

  assign eq = ~(a_bit ^ b_bit);
  assign lt = ~a_bit & b_bit;
  assign gt = a_bit & ~b_bit;

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial, MSB-first magnitude compare of two
// W-bit unsigned operands, one bit per clock.
// Ports:
//  clk     : clock, rising edge
//  reset   : asynchronous active-high reset
//  start   : request, accepted in IDLE and in DONE (back-to-back)
//  a, b    : operands, captured on the accepted start edge
//  busy    : high while in SHIFT or DONE
//  done    : one-cycle pulse, flags valid in this cycle
//  a_eq_b, a_ls_b, a_gt_b : registered one-hot result, held until the next
//                           result or reset (all zero = no result yet)
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         a_eq_b,
  output logic         a_ls_b,
  output logic         a_gt_b
);

  localparam int             CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [W-1:0]     sa_reg, sb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dec_reg;     // first difference already seen
  logic             dir_gt_reg;  // direction of that first difference
  logic [2:0]       flags_reg;   // {eq, ls, gt}

  logic             bit_eq, bit_lt, bit_gt;
  logic             accept, finish;
  logic [2:0]       result;

  cmp_bit_slice u_slice (
    .a_bit (sa_reg[W-1]),
    .b_bit (sb_reg[W-1]),
    .eq    (bit_eq),
    .lt    (bit_lt),
    .gt    (bit_gt)
  );

  // Starting again straight from DONE gives the latency+1 minimum period.
  assign accept = start && (state_reg == IDLE || state_reg == DONE);

  // The walk ends on the last bit, or on the first difference when exiting early.
  assign finish = (state_reg == SHIFT) &&
                  ((cnt_reg == '0) || (EARLY_EXIT && !bit_eq));

  // A recorded earlier difference outranks the current bit; otherwise the
  // slice output is already in {eq, ls, gt} one-hot order.
  assign result = dec_reg ? (dir_gt_reg ? CMP_GT : CMP_LT)
                          : {bit_eq, bit_lt, bit_gt};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (finish) state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Datapath: operand shift registers, bit counter, sticky decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_reg     <= '0;
      sb_reg     <= '0;
      cnt_reg    <= '0;
      dec_reg    <= 1'b0;
      dir_gt_reg <= 1'b0;
    end else if (accept) begin
      sa_reg     <= a;
      sb_reg     <= b;
      cnt_reg    <= CNT_LOAD;
      dec_reg    <= 1'b0;
      dir_gt_reg <= 1'b0;
    end else if (state_reg == SHIFT) begin
      sa_reg  <= sa_reg << 1;
      sb_reg  <= sb_reg << 1;
      cnt_reg <= cnt_reg - CNT_ONE;
      if (!dec_reg && !bit_eq) begin
        dec_reg    <= 1'b1;
        dir_gt_reg <= bit_gt;
      end
    end
  end

  // Result flags, loaded only on the edge entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       flags_reg <= 3'b000;
    else if (finish) flags_reg <= result;
  end

  assign a_eq_b = flags_reg[2];
  assign a_ls_b = flags_reg[1];
  assign a_gt_b = flags_reg[0];

endmodule
